// File: rtl/mem_resp_align.sv
// Tracks outstanding memory requests and turns raw read words into aligned/extended load results.
// Define MEM_RESP_UNALIGN_EN to merge LWL/LWR responses with the old destination value.
module mem_resp_align #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_fire,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic        req_unalign_left,
  input  logic        req_unalign_right,
  input  logic [1:0]  req_addr_lo,
  input  logic [4:0]  req_waddr,
  input  logic [31:0] req_old,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  input  logic        stall,
  output logic        resp_valid,
  output logic [4:0]  resp_waddr,
  output logic [31:0] resp_wdata,
  output logic        stall_resp,
  output logic        proto_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic        sign;
`ifdef MEM_RESP_UNALIGN_EN
    logic        left;
    logic        right;
    logic [31:0] old;
`endif
    logic [1:0]  addr_lo;
    logic [4:0]  waddr;
  } meta_t;

  meta_t            mem [DEPTH];
  meta_t            in_meta;
  meta_t            head;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;

`ifndef MEM_RESP_UNALIGN_EN
  logic unused_unalign;
  assign unused_unalign = ^{req_unalign_left, req_unalign_right, req_old};
`endif

  always_comb begin
    in_meta         = '0;
    in_meta.wr      = req_wr;
    in_meta.size    = req_size;
    in_meta.sign    = req_sign;
    in_meta.addr_lo = req_addr_lo;
    in_meta.waddr   = req_waddr;
`ifdef MEM_RESP_UNALIGN_EN
    in_meta.left    = req_unalign_left;
    in_meta.right   = req_unalign_right;
    in_meta.old     = req_old;
`endif
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);
  assign pop   = data_data_ok && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push  = req_fire && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_meta;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

  logic [31:0] res;
  logic [4:0]  sh_b;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
`ifdef MEM_RESP_UNALIGN_EN
  logic [4:0]  sh_l;
`endif

  always_comb begin
    sh_b   = {head.addr_lo, 3'b000};
    lane_b = 8'(data_rdata >> sh_b);
    lane_h = head.addr_lo[1] ? data_rdata[31:16] : data_rdata[15:0];
    case (head.size)
      2'b00:   res = {{24{head.sign & lane_b[7]}}, lane_b};
      2'b01:   res = {{16{head.sign & lane_h[15]}}, lane_h};
      default: res = data_rdata;
    endcase
`ifdef MEM_RESP_UNALIGN_EN
    // sh_l is 8*(3-a): how far the word slides left for LWL.
    sh_l = 5'd24 - sh_b;
    if (head.left)
      res = (data_rdata << sh_l) | (head.old & ~(32'hFFFF_FFFF << sh_l));
    else if (head.right)
      res = (data_rdata >> sh_b) | (head.old & ~(32'hFFFF_FFFF >> sh_b));
`endif
  end

  // Output handshake: resp_valid=1 with stall=0 means the consumer takes the result at
  // this edge; with stall=1 the result stays put and the next one waits in the skid.
  logic        new_valid;
  logic        out_free;
  logic        drop;
  logic        err_set;
  logic        skid_valid;
  logic [4:0]  skid_waddr;
  logic [31:0] skid_wdata;

  assign new_valid = pop && !head.wr;
  assign out_free  = !resp_valid || !stall;
  assign drop      = new_valid && !out_free && skid_valid;
  assign err_set   = (req_fire && full && !pop) || (data_data_ok && empty) ||
                     (new_valid && head.size == 2'b11) || drop;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resp_valid <= 1'b0;
      resp_waddr <= '0;
      resp_wdata <= '0;
      skid_valid <= 1'b0;
      skid_waddr <= '0;
      skid_wdata <= '0;
      proto_err  <= 1'b0;
    end else begin
      if (out_free) begin
        if (skid_valid) begin
          resp_valid <= 1'b1;
          resp_waddr <= skid_waddr;
          resp_wdata <= skid_wdata;
          skid_valid <= new_valid;
          if (new_valid) begin
            skid_waddr <= head.waddr;
            skid_wdata <= res;
          end
        end else begin
          resp_valid <= new_valid;
          if (new_valid) begin
            resp_waddr <= head.waddr;
            resp_wdata <= res;
          end
        end
      end else if (new_valid && !skid_valid) begin
        skid_valid <= 1'b1;
        skid_waddr <= head.waddr;
        skid_wdata <= res;
      end
      if (err_set) proto_err <= 1'b1;
    end
  end

  assign stall_resp = (!empty && !head.wr && !data_data_ok) || skid_valid;

endmodule

// File: tb/tb_mem_resp_align.sv
// Bench for mem_resp_align: vector table for alignment/extension plus directed stall, skid,
// error and reset sequences; results are checked in order against an expected queue.
module tb_mem_resp_align;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_fire;
  logic        req_wr;
  logic [1:0]  req_size;
  logic        req_sign;
  logic        req_unalign_left;
  logic        req_unalign_right;
  logic [1:0]  req_addr_lo;
  logic [4:0]  req_waddr;
  logic [31:0] req_old;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        stall;
  logic        resp_valid;
  logic [4:0]  resp_waddr;
  logic [31:0] resp_wdata;
  logic        stall_resp;
  logic        proto_err;

  mem_resp_align #(.DEPTH(2)) dut (
    .clk(clk), .resetn(resetn),
    .req_fire(req_fire), .req_wr(req_wr), .req_size(req_size), .req_sign(req_sign),
    .req_unalign_left(req_unalign_left), .req_unalign_right(req_unalign_right),
    .req_addr_lo(req_addr_lo), .req_waddr(req_waddr), .req_old(req_old),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata), .stall(stall),
    .resp_valid(resp_valid), .resp_waddr(resp_waddr), .resp_wdata(resp_wdata),
    .stall_resp(stall_resp), .proto_err(proto_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

`ifdef MEM_RESP_UNALIGN_EN
  localparam bit UA = 1'b1;
`else
  localparam bit UA = 1'b0;
`endif

  typedef struct {
    logic [1:0]  size;
    logic        sign;
    logic        left;
    logic        right;
    logic [1:0]  a;
    logic [31:0] rdata;
    logic [31:0] old;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[16];
  logic [36:0] exp_q[$];
  logic [36:0] mon_got;
  logic [36:0] mon_exp;
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic vec_t mk(input logic [1:0] size, input logic sign, input logic left,
                              input logic right, input logic [1:0] a, input logic [31:0] rdata,
                              input logic [31:0] old, input logic [31:0] exp);
    vec_t v;
    v.size = size; v.sign = sign; v.left = left; v.right = right;
    v.a = a; v.rdata = rdata; v.old = old; v.exp = exp;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    req_fire = 1'b0; req_wr = 1'b0; req_size = 2'b10; req_sign = 1'b0;
    req_unalign_left = 1'b0; req_unalign_right = 1'b0; req_addr_lo = 2'b00;
    req_waddr = 5'd0; req_old = 32'd0; data_data_ok = 1'b0; data_rdata = 32'd0;
  endtask

  task automatic set_req(input logic wr, input logic [1:0] size, input logic sign,
                         input logic left, input logic right, input logic [1:0] a,
                         input logic [4:0] wa, input logic [31:0] old);
    req_fire = 1'b1; req_wr = wr; req_size = size; req_sign = sign;
    req_unalign_left = left; req_unalign_right = right; req_addr_lo = a;
    req_waddr = wa; req_old = old;
  endtask

  task automatic load_req(input logic [4:0] wa);
    set_req(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, wa, 32'd0);
  endtask

  task automatic respond(input logic [31:0] rd, input logic is_load, input logic [4:0] wa,
                         input logic [31:0] exp);
    data_data_ok = 1'b1;
    data_rdata   = rd;
    if (is_load) exp_q.push_back({wa, exp});
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    clear_inputs();
    stall = 1'b0;
    step();
    step();
    resetn = 1'b1;
    step();
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (resetn && resp_valid && !stall) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_resp: got waddr %0d data %h, expected no result",
                 resp_waddr, resp_wdata);
      end else begin
        mon_got = {resp_waddr, resp_wdata};
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          n_err++;
          $display("FAIL resp_data: got waddr %0d data %h, expected waddr %0d data %h",
                   mon_got[36:32], mon_got[31:0], mon_exp[36:32], mon_exp[31:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- test ----------------
  initial begin
    vecs[0]  = mk(2'b00, 1'b1, 1'b0, 1'b0, 2'd2, 32'h1284_5678, 32'd0, 32'hFFFF_FF84);
    vecs[1]  = mk(2'b00, 1'b0, 1'b0, 1'b0, 2'd2, 32'h1284_5678, 32'd0, 32'h0000_0084);
    vecs[2]  = mk(2'b00, 1'b1, 1'b0, 1'b0, 2'd0, 32'h1284_5678, 32'd0, 32'h0000_0078);
    vecs[3]  = mk(2'b00, 1'b1, 1'b0, 1'b0, 2'd3, 32'h9234_5678, 32'd0, 32'hFFFF_FF92);
    vecs[4]  = mk(2'b00, 1'b0, 1'b0, 1'b0, 2'd1, 32'h1284_5678, 32'd0, 32'h0000_0056);
    vecs[5]  = mk(2'b01, 1'b0, 1'b0, 1'b0, 2'd2, 32'h8001_1234, 32'd0, 32'h0000_8001);
    vecs[6]  = mk(2'b01, 1'b1, 1'b0, 1'b0, 2'd2, 32'h8001_1234, 32'd0, 32'hFFFF_8001);
    vecs[7]  = mk(2'b01, 1'b1, 1'b0, 1'b0, 2'd0, 32'h8001_1234, 32'd0, 32'h0000_1234);
    vecs[8]  = mk(2'b01, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0000_F00D, 32'd0, 32'hFFFF_F00D);
    vecs[9]  = mk(2'b10, 1'b0, 1'b0, 1'b0, 2'd0, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF);
    vecs[10] = mk(2'b10, 1'b1, 1'b0, 1'b0, 2'd0, 32'h8000_0001, 32'd0, 32'h8000_0001);
    vecs[11] = mk(2'b10, 1'b0, 1'b1, 1'b0, 2'd1, 32'hAABB_CCDD, 32'h1122_3344,
                  UA ? 32'hCCDD_3344 : 32'hAABB_CCDD);
    vecs[12] = mk(2'b10, 1'b0, 1'b0, 1'b1, 2'd1, 32'hAABB_CCDD, 32'h1122_3344,
                  UA ? 32'h11AA_BBCC : 32'hAABB_CCDD);
    vecs[13] = mk(2'b10, 1'b0, 1'b1, 1'b0, 2'd0, 32'hAABB_CCDD, 32'h1122_3344,
                  UA ? 32'hDD22_3344 : 32'hAABB_CCDD);
    vecs[14] = mk(2'b10, 1'b0, 1'b0, 1'b1, 2'd3, 32'hAABB_CCDD, 32'h1122_3344,
                  UA ? 32'h1122_33AA : 32'hAABB_CCDD);
    vecs[15] = mk(2'b10, 1'b0, 1'b1, 1'b0, 2'd2, 32'hAABB_CCDD, 32'h1122_3344,
                  UA ? 32'hBBCC_DD44 : 32'hAABB_CCDD);

    clear_inputs();
    stall  = 1'b0;
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #1;
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    check("reset_resp_waddr", 32'(resp_waddr), 32'd0);
    check("reset_resp_wdata", resp_wdata, 32'd0);
    check("reset_stall_resp", 32'(stall_resp), 32'd0);
    check("reset_proto_err", 32'(proto_err), 32'd0);
    step();
    step();
    resetn = 1'b1;
    step();

    // Alignment / extension table, one load at a time.
    for (int i = 0; i < 16; i++) begin
      set_req(1'b0, vecs[i].size, vecs[i].sign, vecs[i].left, vecs[i].right, vecs[i].a,
              5'(i + 1), vecs[i].old);
      step();
      req_fire = 1'b0;
      check("stall_resp_wait", 32'(stall_resp), 32'd1);
      respond(vecs[i].rdata, 1'b1, 5'(i + 1), vecs[i].exp);
      step();
      data_data_ok = 1'b0;
      check("latency_valid", 32'(resp_valid), 32'd1);
      step();
      check("valid_drops", 32'(resp_valid), 32'd0);
    end
    check("table_no_err", 32'(proto_err), 32'd0);

    // Back-to-back loads under stall: first held in output, second in skid.
    stall = 1'b1;
    load_req(5'd3);
    step();
    load_req(5'd4);
    check("stall_resp_pending", 32'(stall_resp), 32'd1);
    step();
    req_fire = 1'b0;
    respond(32'h1111_0001, 1'b1, 5'd3, 32'h1111_0001);
    step();
    check("first_into_out", 32'(resp_valid), 32'd1);
    respond(32'h2222_0002, 1'b1, 5'd4, 32'h2222_0002);
    step();
    data_data_ok = 1'b0;
    check("held_valid", 32'(resp_valid), 32'd1);
    check("held_waddr", 32'(resp_waddr), 32'd3);
    check("held_data", resp_wdata, 32'h1111_0001);
    check("skid_stall_resp", 32'(stall_resp), 32'd1);
    step();
    check("still_held", resp_wdata, 32'h1111_0001);
    stall = 1'b0;
    step();
    check("second_out", resp_wdata, 32'h2222_0002);
    check("skid_empty", 32'(stall_resp), 32'd0);
    step();
    check("drained", 32'(resp_valid), 32'd0);
    check("skid_no_err", 32'(proto_err), 32'd0);

    // Full FIFO pop+push, then a third result with output and skid both full.
    stall = 1'b1;
    load_req(5'd5);
    step();
    load_req(5'd6);
    step();
    load_req(5'd7);
    respond(32'hA000_000A, 1'b1, 5'd5, 32'hA000_000A);
    step();
    req_fire = 1'b0;
    check("full_pop_push_ok", 32'(proto_err), 32'd0);
    respond(32'hB000_000B, 1'b1, 5'd6, 32'hB000_000B);
    step();
    data_data_ok = 1'b1;
    data_rdata   = 32'hC000_000C;
    step();
    data_data_ok = 1'b0;
    check("drop_err", 32'(proto_err), 32'd1);
    check("drop_keeps_out", resp_wdata, 32'hA000_000A);
    stall = 1'b0;
    step();
    check("drop_keeps_skid", resp_wdata, 32'hB000_000B);
    step();
    check("drop_not_emitted", 32'(resp_valid), 32'd0);
    check("drop_fifo_empty", 32'(stall_resp), 32'd0);
    do_reset();

    // Store then load: exactly one result.
    set_req(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 5'd8, 32'd0);
    step();
    load_req(5'd9);
    step();
    req_fire = 1'b0;
    check("store_head_no_stall", 32'(stall_resp), 32'd0);
    respond(32'h5555_5555, 1'b0, 5'd8, 32'd0);
    step();
    check("store_no_resp", 32'(resp_valid), 32'd0);
    respond(32'h6666_6666, 1'b1, 5'd9, 32'h6666_6666);
    step();
    data_data_ok = 1'b0;
    check("load_resp", 32'(resp_valid), 32'd1);
    step();
    check("one_pulse", 32'(resp_valid), 32'd0);
    check("store_no_err", 32'(proto_err), 32'd0);

    // Push into a full FIFO with no pop is dropped.
    load_req(5'd10);
    step();
    load_req(5'd11);
    step();
    check("full_no_err", 32'(proto_err), 32'd0);
    load_req(5'd12);
    step();
    req_fire = 1'b0;
    check("overflow_err", 32'(proto_err), 32'd1);
    respond(32'h7777_0000, 1'b1, 5'd10, 32'h7777_0000);
    step();
    respond(32'h8888_0000, 1'b1, 5'd11, 32'h8888_0000);
    step();
    data_data_ok = 1'b0;
    check("overflow_dropped", 32'(stall_resp), 32'd0);
    step();
    do_reset();

    // Size 11 behaves as a word load and flags an error.
    set_req(1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 2'b00, 5'd13, 32'd0);
    step();
    req_fire = 1'b0;
    check("size11_pre", 32'(proto_err), 32'd0);
    respond(32'hABCD_1234, 1'b1, 5'd13, 32'hABCD_1234);
    step();
    data_data_ok = 1'b0;
    check("size11_data", resp_wdata, 32'hABCD_1234);
    check("size11_err", 32'(proto_err), 32'd1);
    step();

    // Asynchronous reset with two entries queued and a held result.
    stall = 1'b1;
    load_req(5'd14);
    step();
    load_req(5'd15);
    step();
    load_req(5'd16);
    data_data_ok = 1'b1;
    data_rdata   = 32'h1234_5678;
    step();
    clear_inputs();
    check("pre_reset_valid", 32'(resp_valid), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("async_resp_valid", 32'(resp_valid), 32'd0);
    check("async_resp_waddr", 32'(resp_waddr), 32'd0);
    check("async_resp_wdata", resp_wdata, 32'd0);
    check("async_stall_resp", 32'(stall_resp), 32'd0);
    check("async_proto_err", 32'(proto_err), 32'd0);
    step();
    stall  = 1'b0;
    resetn = 1'b1;
    step();
    data_data_ok = 1'b1;
    data_rdata   = 32'h9999_9999;
    step();
    data_data_ok = 1'b0;
    check("empty_pop_err", 32'(proto_err), 32'd1);
    check("empty_pop_no_resp", 32'(resp_valid), 32'd0);
    step();
    do_reset();

    // Random word loads with random stall.
    for (int k = 0; k < 12; k++) begin
      logic [31:0] rd;
      logic [4:0]  wa;
      rd = $urandom();
      wa = 5'($urandom_range(0, 31));
      stall = 1'($urandom_range(0, 1));
      load_req(wa);
      step();
      req_fire = 1'b0;
      stall = 1'($urandom_range(0, 1));
      respond(rd, 1'b1, wa, rd);
      step();
      data_data_ok = 1'b0;
      stall = 1'b0;
      step();
      step();
    end
    check("random_no_err", 32'(proto_err), 32'd0);
    check("leftover_expected", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
